trivium_ks_xor: RTL and testbench

//  Keystream consumer placed directly downstream of the Trivium generator.
//  - Requests 128-bit keystream blocks from the generator (KsReq drives the generator's Drdy).
//  - Captures each block when the generator pulses its Dvld.
//  - XORs a byte stream against the block, MSB byte first, to produce cipher/plain bytes.
//  - Valid/ready on both byte ports; one block is buffered (two with prefetch).

---
 rtl/trivium_ks_xor.sv | 168 ++++++++++++++++
 tb/tb_trivium_ks_xor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ks_xor.sv
// -----------------------------------------------------------------------------
// trivium_ks_xor
//   Keystream consumer that sits directly downstream of a Trivium generator.
//   It requests 128-bit keystream blocks, captures them, and XORs a byte
//   stream against each block, MSB byte first. Valid/ready on both byte ports.
//
// Configuration macro:
//   TRIVIUM_KS_PREFETCH_EN - adds a second block buffer so that the next
//                            block is fetched while the current one is being
//                            consumed (no bubble between blocks).
//
// Ports:
//   CLK       in   1     system clock
//   RST       in   1     synchronous reset, active-high
//   EN        in   1     block enable; low freezes all state
//   KsReq     out  1     1-cycle request pulse to the generator (Drdy)
//   KsIn      in   KS_W  keystream block (generator Dout)
//   KsVld     in   1     1-cycle pulse, KsIn valid (generator Dvld)
//   DinVld    in   1     input byte valid
//   DinRdy    out  1     input byte ready
//   Din       in   DW    input byte
//   DinLast   in   1     last byte of a message
//   DoutVld   out  1     output byte valid
//   DoutRdy   in   1     downstream ready
//   Dout      out  DW    Din ^ keystream byte
//   DoutLast  out  1     DinLast carried with the output byte
// -----------------------------------------------------------------------------
module trivium_ks_xor #(
  parameter int KS_W = 128,
  parameter int DW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  output logic            KsReq,
  input  logic [KS_W-1:0] KsIn,
  input  logic            KsVld,
  input  logic            DinVld,
  output logic            DinRdy,
  input  logic [DW-1:0]   Din,
  input  logic            DinLast,
  output logic            DoutVld,
  input  logic            DoutRdy,
  output logic [DW-1:0]   Dout,
  output logic            DoutLast
);

  localparam int NB = KS_W / DW;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic              outstanding;
  logic              ks_req_q;
  logic [KS_W-1:0]   act_buf;
`ifdef TRIVIUM_KS_PREFETCH_EN
  logic [KS_W-1:0]   nxt_buf;
  logic              nxt_vld;
`endif

  logic              hs;
  logic              consume;
  logic [KS_W-1:0]   ks_sh;
  logic [DW-1:0]     ks_byte;

  // Ready depends only on registered state plus the downstream ready, so a
  // stalled output register blocks the input in the same cycle.
  assign DinRdy  = EN & (state == S_FULL) & (~DoutVld | DoutRdy);
  // The request is a registered pulse, masked so it never shows while frozen.
  assign KsReq   = ks_req_q & EN;
  assign hs      = DinVld & DinRdy;
  assign consume = hs & ((ptr == PW'(NB - 1)) | DinLast);

  // Byte k of the block is the k-th DW slice from the MSB end.
  assign ks_sh   = act_buf << (DW * ptr);
  assign ks_byte = ks_sh[KS_W-1 -: DW];

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the block buffers are reset too, so no stale keystream can be
      // observed after a mid-operation reset.
      state       <= S_EMPTY;
      ptr         <= '0;
      outstanding <= 1'b0;
      ks_req_q    <= 1'b0;
      act_buf     <= '0;
      Dout        <= '0;
      DoutLast    <= 1'b0;
      DoutVld     <= 1'b0;
`ifdef TRIVIUM_KS_PREFETCH_EN
      nxt_buf     <= '0;
      nxt_vld     <= 1'b0;
`endif
    end else if (EN) begin
      ks_req_q <= 1'b0;

      // Output register: load on handshake, otherwise drop valid once taken.
      if (hs) begin
        Dout     <= Din ^ ks_byte;
        DoutLast <= DinLast;
        DoutVld  <= 1'b1;
      end else if (DoutVld && DoutRdy) begin
        DoutVld  <= 1'b0;
      end

      unique case (state)
        S_EMPTY: begin
          ks_req_q    <= 1'b1;
          outstanding <= 1'b1;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (KsVld) begin
            act_buf     <= KsIn;
            ptr         <= '0;
            outstanding <= 1'b0;
            state       <= S_FULL;
          end
        end

        S_FULL: begin
          if (consume) begin
`ifdef TRIVIUM_KS_PREFETCH_EN
            if (nxt_vld) begin
              // Promote the prefetched block with no ready bubble.
              act_buf <= nxt_buf;
              nxt_vld <= 1'b0;
              ptr     <= '0;
            end else if (outstanding && KsVld) begin
              // Prefetched block lands exactly as the active one runs out.
              act_buf     <= KsIn;
              outstanding <= 1'b0;
              ptr         <= '0;
            end else if (outstanding) begin
              // A request is already in flight; do not issue a second one.
              state <= S_WAIT;
            end else begin
              state <= S_EMPTY;
            end
`else
            state <= S_EMPTY;
`endif
          end else begin
            if (hs) ptr <= ptr + 1'b1;
`ifdef TRIVIUM_KS_PREFETCH_EN
            if (outstanding && KsVld) begin
              nxt_buf     <= KsIn;
              nxt_vld     <= 1'b1;
              outstanding <= 1'b0;
            end else if (!nxt_vld && !outstanding) begin
              ks_req_q    <= 1'b1;
              outstanding <= 1'b1;
            end
`endif
          end
        end

        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_ks_xor.sv
// -----------------------------------------------------------------------------
// tb_trivium_ks_xor
//   Self-checking bench for trivium_ks_xor. Stimulus pushes the expected
//   {DoutLast, Dout} into a scoreboard queue at each input handshake; a
//   separate monitor pops and compares on every output transfer.
//   Built with TRIVIUM_KS_PREFETCH_EN it runs the back-to-back prefetch case;
//   otherwise it runs the single-buffer cases.
// -----------------------------------------------------------------------------
module tb_trivium_ks_xor;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         KsReq;
  logic [127:0] KsIn = '0;
  logic         KsVld = 1'b0;
  logic         DinVld = 1'b0;
  logic         DinRdy;
  logic [7:0]   Din = '0;
  logic         DinLast = 1'b0;
  logic         DoutVld;
  logic         DoutRdy = 1'b1;
  logic [7:0]   Dout;
  logic         DoutLast;

  trivium_ks_xor dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .KsReq(KsReq), .KsIn(KsIn), .KsVld(KsVld),
    .DinVld(DinVld), .DinRdy(DinRdy), .Din(Din), .DinLast(DinLast),
    .DoutVld(DoutVld), .DoutRdy(DoutRdy), .Dout(Dout), .DoutLast(DoutLast)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  logic [8:0] sb_q[$];

  localparam logic [127:0] B1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] B2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] B3 = 128'hDEADBEEFCAFEF00D0BADC0DE8BADF00D;
  localparam logic [127:0] B4 = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;
  localparam logic [127:0] B5 = 128'h1111111122222222333333334444444D;
  localparam logic [127:0] B6 = 128'h6C6B6A69686766656463626160FFEE99;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] kb(input logic [127:0] b, input int k);
    logic [127:0] s;
    s = b >> (120 - 8 * k);
    return s[7:0];
  endfunction

  // Monitor: compares each transferred output byte against the scoreboard.
  always @(negedge CLK) begin
    if (!RST && DoutVld && DoutRdy) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_dout: got %0h, want nothing queued", {DoutLast, Dout});
      end else begin
        check("dout_last", 32'({DoutLast, Dout}), 32'(sb_q.pop_front()));
      end
    end
  end

  // Send one byte; expected result uses the keystream byte supplied by caller.
  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] ks);
    bit ok = 0;
    DinVld  = 1'b1;
    Din     = d;
    DinLast = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (DinRdy) begin
        sb_q.push_back({last, d ^ ks});
        hs_cyc = cyc;
        ok = 1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: DinRdy stayed 0, want 1 for byte %0h", d);
    end
    @(posedge CLK); #1;
    DinVld  = 1'b0;
    DinLast = 1'b0;
  endtask

  // Generator stand-in: wait for a request, check it is a single-cycle
  // pulse, then deliver the block a few cycles later.
  task automatic provide_block(input logic [127:0] blk, input bit idle);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (KsReq) found = 1;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL ksreq_timeout: KsReq stayed 0, want a pulse");
    end
    @(negedge CLK);
    check("ksreq_pulse_width", 32'(KsReq), 32'd0);
    if (idle) check("dinrdy_while_waiting", 32'(DinRdy), 32'd0);
    @(posedge CLK); #1;
    KsIn  = blk;
    KsVld = 1'b1;
    @(posedge CLK); #1;
    KsVld = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    repeat (cycles) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2_exp [16];
    t2_exp = '{8'h01, 8'h22, 8'h47, 8'h64, 8'h8D, 8'hAE, 8'hCB, 8'hE8,
               8'hF6, 8'hD5, 8'hB0, 8'h93, 8'h7A, 8'h59, 8'h3C, 8'h1F};

    // T1: reset values, then a single KsReq pulse once enabled.
    do_reset(2);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_ksreq",   32'(KsReq),   32'd0);
    check("rst_dinrdy",  32'(DinRdy),  32'd0);
    check("rst_doutvld", 32'(DoutVld), 32'd0);
    check("rst_dout",    32'({DoutLast, Dout}), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    EN  = 1'b1;

`ifdef TRIVIUM_KS_PREFETCH_EN
    // T6: two blocks back to back; ready must never drop.
    fork
      begin
        provide_block(B1, 1);
        provide_block(B2, 0);
      end
      begin
        int prev;
        for (int k = 0; k < 32; k++) begin
          send(8'(k * 7 + 3), 1'b0, (k < 16) ? kb(B1, k) : kb(B2, k - 16));
          if (k > 0) check("prefetch_no_bubble", 32'(hs_cyc - prev), 32'd1);
          prev = hs_cyc;
        end
      end
    join
`else
    provide_block(B1, 1);

    // T2: full block XOR against hand-computed results.
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0, t2_exp[k] ^ 8'(k));
    @(negedge CLK);
    check("dinrdy_after_block", 32'(DinRdy), 32'd0);

    // T3: downstream stall mid-block holds the output and blocks input.
    provide_block(B2, 1);
    for (int k = 0; k < 6; k++) send(8'h40 + 8'(k), 1'b0, kb(B2, k));
    DoutRdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_doutvld", 32'(DoutVld), 32'd1);
      check("stall_dout",    32'(Dout), 32'(8'h45 ^ kb(B2, 5)));
      check("stall_dinrdy",  32'(DinRdy), 32'd0);
    end
    @(posedge CLK); #1;
    DoutRdy = 1'b1;
    for (int k = 6; k < 16; k++) send(8'h40 + 8'(k), 1'b0, kb(B2, k));

    // T4: early DinLast discards the rest; next message starts a new block.
    provide_block(B3, 1);
    for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), k == 3, kb(B3, k));
    @(negedge CLK);
    check("dinrdy_after_last", 32'(DinRdy), 32'd0);
    provide_block(B4, 1);
    send(8'h5C, 1'b1, kb(B4, 0));

    // T5: reset while waiting; a late block during reset is dropped.
    for (int i = 0; i < 100 && !KsReq; i++) @(negedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    KsIn  = B5;
    KsVld = 1'b1;
    @(posedge CLK); #1;
    KsVld = 1'b0;
    RST   = 1'b0;
    @(negedge CLK);
    check("post_rst_dinrdy",  32'(DinRdy), 32'd0);
    check("post_rst_doutvld", 32'(DoutVld), 32'd0);
    provide_block(B6, 1);
    send(8'h77, 1'b0, kb(B6, 0));
    send(8'h88, 1'b1, kb(B6, 1));
`endif

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
